// File: rtl/sd_init_seq.sv
// sd_init_seq: walks an SD card through SD-mode initialisation
// (CMD0, CMD8, CMD55/ACMD41 poll, CMD2, CMD3, CMD7) over a command
// transmitter / response receiver pair, then reports RCA/CCS or an error.
`timescale 1ns/1ps

module sd_init_seq #(
  parameter int RSP_TIMEOUT  = 1024,  // cycles allowed from tx_busy fall to rsp_valid
  parameter int ACMD41_RETRY = 1000,  // ACMD41 attempts before giving up
  parameter int GAP_CYC      = 16     // idle cycles between commands (>= 1)
) (
  input  logic        ctrl_clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        tx_en,
  output logic [5:0]  tx_cmd,
  output logic [31:0] tx_para,
  input  logic        tx_busy,
  input  logic        rsp_valid,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg,
  input  logic        rsp_crc_ok,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  output logic [15:0] o_rca,
  output logic        o_ccs
);

  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
  localparam int RTY_W = $clog2(ACMD41_RETRY + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(ACMD41_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND, S_WAIT_TX_HI, S_WAIT_TX_LO, S_WAIT_RSP,
    S_CHECK, S_GAP, S_DONE, S_ERR
  } state_t;

  // ST_FIN marks "CMD7 accepted": the trailing gap then lands in DONE.
  typedef enum logic [2:0] {
    ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3, ST_CMD7, ST_FIN
  } step_t;

  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_TIMEOUT = 3'd1,
    E_ECHO    = 3'd2,
    E_CRC     = 3'd3,
    E_INDEX   = 3'd4,
    E_RETRY   = 3'd5
  } err_t;

  state_t           r_state, w_state_nxt;
  step_t            r_step, w_step_nxt;
  err_t             r_err_code, w_err_code_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [RTY_W-1:0] r_retry, w_retry_nxt;
  logic [15:0]      r_rca, w_rca_nxt;
  logic             r_ccs, w_ccs_nxt;

  logic [5:0]       r_rsp_index;
  logic [31:0]      r_rsp_arg;
  logic             r_rsp_crc_ok;
  logic             w_rsp_latch;

  logic [5:0]       w_cmd;
  logic [31:0]      w_para;
  logic             w_r1_check;
  logic [RTY_W-1:0] w_retry_inc;
  logic             w_unused_arg;

  // Command index and argument for the current step.
  always_comb begin
    w_cmd  = 6'd0;
    w_para = 32'd0;
    case (r_step)
      ST_CMD8:   begin w_cmd = 6'd8;  w_para = 32'h0000_01AA;   end
      ST_CMD55:  begin w_cmd = 6'd55; w_para = 32'd0;           end
      ST_ACMD41: begin w_cmd = 6'd41; w_para = 32'h40FF_8000;   end
      ST_CMD2:   begin w_cmd = 6'd2;  w_para = 32'd0;           end
      ST_CMD3:   begin w_cmd = 6'd3;  w_para = 32'd0;           end
      ST_CMD7:   begin w_cmd = 6'd7;  w_para = {r_rca, 16'h0}; end
      default:   ;
    endcase
  end

  // R1/R6 replies carry a real index and CRC; R3 (ACMD41) and R2 (CMD2) do not.
  assign w_r1_check  = (r_step == ST_CMD8) || (r_step == ST_CMD55) ||
                       (r_step == ST_CMD3) || (r_step == ST_CMD7);
  assign w_retry_inc = r_retry + 1'b1;

  // Next-state logic and next values for every sequencer register.
  always_comb begin
    // NOTE: every variable gets a default before the case; a path that
    // skipped an assignment would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_err_code_nxt = r_err_code;
    w_tmo_nxt      = r_tmo;
    w_gap_nxt      = r_gap;
    w_retry_nxt    = r_retry;
    w_rca_nxt      = r_rca;
    w_ccs_nxt      = r_ccs;
    w_rsp_latch    = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          w_state_nxt    = S_SEND;
          w_step_nxt     = ST_CMD0;
          w_retry_nxt    = '0;
          w_err_code_nxt = E_NONE;
        end
      end

      S_SEND: w_state_nxt = S_WAIT_TX_HI;

      S_WAIT_TX_HI: begin
        if (tx_busy) w_state_nxt = S_WAIT_TX_LO;
      end

      S_WAIT_TX_LO: begin
        if (!tx_busy) begin
          if (r_step == ST_CMD0) begin
            // CMD0 has no response: straight into the post-reset gap.
            w_step_nxt  = ST_CMD8;
            w_gap_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_tmo_nxt   = '0;
            w_state_nxt = S_WAIT_RSP;
          end
        end
      end

      S_WAIT_RSP: begin
        if (rsp_valid) begin
          w_rsp_latch = 1'b1;
          w_state_nxt = S_CHECK;
        end else if (r_tmo == TMO_LAST) begin
          w_err_code_nxt = E_TIMEOUT;
          w_state_nxt    = S_ERR;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      S_CHECK: begin
        w_gap_nxt   = '0;
        w_state_nxt = S_GAP;
        if (w_r1_check && !r_rsp_crc_ok) begin
          w_err_code_nxt = E_CRC;
          w_state_nxt    = S_ERR;
        end else if (w_r1_check && (r_rsp_index != w_cmd)) begin
          w_err_code_nxt = E_INDEX;
          w_state_nxt    = S_ERR;
        end else begin
          case (r_step)
            ST_CMD8: begin
              if (r_rsp_arg[11:0] != 12'h1AA) begin
                w_err_code_nxt = E_ECHO;
                w_state_nxt    = S_ERR;
              end else begin
                w_step_nxt = ST_CMD55;
              end
            end
            ST_CMD55: w_step_nxt = ST_ACMD41;
            ST_ACMD41: begin
              if (r_rsp_arg[31]) begin
                w_ccs_nxt  = r_rsp_arg[30];
                w_step_nxt = ST_CMD2;
              end else begin
                w_retry_nxt = w_retry_inc;
                if (w_retry_inc == RTY_MAX) begin
                  w_err_code_nxt = E_RETRY;
                  w_state_nxt    = S_ERR;
                end else begin
                  w_step_nxt = ST_CMD55;
                end
              end
            end
            ST_CMD2: w_step_nxt = ST_CMD3;
            ST_CMD3: begin
              w_rca_nxt  = r_rsp_arg[31:16];
              w_step_nxt = ST_CMD7;
            end
            ST_CMD7: w_step_nxt = ST_FIN;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end

      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = (r_step == ST_FIN) ? S_DONE : S_SEND;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any sequence in flight.
  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= ST_CMD0;
      r_err_code <= E_NONE;
      r_tmo      <= '0;
      r_gap      <= '0;
      r_retry    <= '0;
      r_rca      <= '0;
      r_ccs      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_err_code <= w_err_code_nxt;
      r_tmo      <= w_tmo_nxt;
      r_gap      <= w_gap_nxt;
      r_retry    <= w_retry_nxt;
      r_rca      <= w_rca_nxt;
      r_ccs      <= w_ccs_nxt;
    end
  end

  // Capture the response fields so CHECK works on a stable copy.
  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_index  <= '0;
      r_rsp_arg    <= '0;
      r_rsp_crc_ok <= 1'b0;
    end else if (w_rsp_latch) begin
      r_rsp_index  <= rsp_index;
      r_rsp_arg    <= rsp_arg;
      r_rsp_crc_ok <= rsp_crc_ok;
    end
  end

  // Argument bits [15:12] carry card status that initialisation never inspects.
  assign w_unused_arg = ^r_rsp_arg[15:12];

  assign tx_en      = (r_state == S_SEND);
  assign tx_cmd     = w_cmd;
  assign tx_para    = w_para;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = (r_state == S_ERR);
  assign o_err_code = r_err_code;
  assign o_rca      = r_rca;
  assign o_ccs      = r_ccs;

endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: directed scenarios against a transmitter/card model.
// Stimulus pushes the expected command requests and final status into a
// queue; a monitor pops and compares whenever the DUT issues tx_en or
// raises o_done/o_err.
`timescale 1ns/1ps

module tb_sd_init_seq;

  localparam int T        = 64;  // response timeout under test
  localparam int RETRY    = 5;   // ACMD41 attempt limit under test
  localparam int GAP      = 16;
  localparam int BUSY_CYC = 4;   // transmitter busy time

  typedef struct {
    bit          is_end;
    logic [5:0]  cmd;
    logic [31:0] para;
    logic        done;
    logic        err;
    logic [2:0]  code;
    logic [15:0] rca;
    logic        ccs;
  } exp_t;

  logic        clk, rst_n, i_start;
  logic        tx_en, tx_busy;
  logic [5:0]  tx_cmd;
  logic [31:0] tx_para;
  logic        rsp_valid, rsp_crc_ok;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;
  logic        o_busy, o_done, o_err, o_ccs;
  logic [2:0]  o_err_code;
  logic [15:0] o_rca;

  sd_init_seq #(.RSP_TIMEOUT(T), .ACMD41_RETRY(RETRY), .GAP_CYC(GAP)) dut (
    .ctrl_clk   (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .tx_en      (tx_en),
    .tx_cmd     (tx_cmd),
    .tx_para    (tx_para),
    .tx_busy    (tx_busy),
    .rsp_valid  (rsp_valid),
    .rsp_index  (rsp_index),
    .rsp_arg    (rsp_arg),
    .rsp_crc_ok (rsp_crc_ok),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_rca      (o_rca),
    .o_ccs      (o_ccs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t q[$];

  // Card behaviour knobs, set per scenario.
  logic [31:0] cfg_cmd8_arg;
  int          cfg_busy_n;
  logic [31:0] cfg_ready_arg;
  logic [31:0] cfg_cmd3_arg;
  logic        cfg_cmd3_crc;
  logic [5:0]  cfg_cmd7_idx;
  int          cfg_mute_cmd;
  int          cfg_delay;
  int          acmd41_cnt;
  int          epoch = 0;
  int          busy_fall_edge = 0;
  int          last_fall_cmd = -1;
  int          end_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_defaults();
    cfg_cmd8_arg  = 32'h0000_01AA;
    cfg_busy_n    = 0;
    cfg_ready_arg = 32'hC0FF_8000;
    cfg_cmd3_arg  = 32'h1234_0000;
    cfg_cmd3_crc  = 1'b1;
    cfg_cmd7_idx  = 6'd7;
    cfg_mute_cmd  = -1;
    cfg_delay     = 5;
    acmd41_cnt    = 0;
  endtask

  // Transmitter + card model: busy for BUSY_CYC cycles per request, then
  // an optional response pulse cfg_delay cycles after busy falls.
  logic [5:0] m_cmd;
  int         m_ep;
  initial begin
    tx_busy = 1'b0; rsp_valid = 1'b0; rsp_index = '0; rsp_arg = '0; rsp_crc_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_en) begin
        m_cmd   = tx_cmd;
        m_ep    = epoch;
        tx_busy = 1'b1;
        repeat (BUSY_CYC) @(negedge clk);
        tx_busy        = 1'b0;
        busy_fall_edge = cyc + 1;  // first edge that samples busy low
        last_fall_cmd  = int'(m_cmd);
        if (m_cmd != 6'd0 && int'(m_cmd) != cfg_mute_cmd) begin
          repeat (cfg_delay) @(negedge clk);
          if (m_ep == epoch && rst_n) begin
            case (m_cmd)
              6'd8:  begin rsp_index = 6'd8;  rsp_crc_ok = 1'b1; rsp_arg = cfg_cmd8_arg; end
              6'd55: begin rsp_index = 6'd55; rsp_crc_ok = 1'b1; rsp_arg = 32'h0000_0120; end
              6'd41: begin
                acmd41_cnt++;
                rsp_index  = 6'h3F;
                rsp_crc_ok = 1'b0;
                rsp_arg    = (acmd41_cnt <= cfg_busy_n) ? 32'h00FF_8000 : cfg_ready_arg;
              end
              6'd2:  begin rsp_index = 6'h3F; rsp_crc_ok = 1'b0; rsp_arg = 32'hDEAD_BEEF; end
              6'd3:  begin rsp_index = 6'd3; rsp_crc_ok = cfg_cmd3_crc; rsp_arg = cfg_cmd3_arg; end
              default: begin rsp_index = cfg_cmd7_idx; rsp_crc_ok = 1'b1; rsp_arg = 32'h0000_0900; end
            endcase
            rsp_valid = 1'b1;
            @(negedge clk);
            rsp_valid = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation for every tx_en and every rise of done/err.
  exp_t mon_e;
  logic end_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        end_prev = 1'b0;
      end else begin
        if (tx_en) begin
          if (q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_tx_en: got cmd %0d para 0x%08h, expected no request", tx_cmd, tx_para);
          end else begin
            mon_e = q.pop_front();
            check($sformatf("tx_kind_cmd%0d", mon_e.cmd), {63'd0, mon_e.is_end}, 64'd0);
            check($sformatf("tx_cmd_exp%0d", mon_e.cmd), tx_cmd, mon_e.cmd);
            check($sformatf("tx_para_cmd%0d", mon_e.cmd), tx_para, mon_e.para);
          end
        end
        if ((o_done || o_err) && !end_prev) begin
          end_edge = cyc;
          if (q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_end: got done=%0b err=%0b code=%0d, expected no completion", o_done, o_err, o_err_code);
          end else begin
            mon_e = q.pop_front();
            check("end_kind", {63'd0, mon_e.is_end}, 64'd1);
            check("end_done", o_done, mon_e.done);
            check("end_err", o_err, mon_e.err);
            check("end_err_code", o_err_code, mon_e.code);
            check("end_rca", o_rca, mon_e.rca);
            check("end_ccs", o_ccs, mon_e.ccs);
            check("end_busy_low", o_busy, 1'b0);
          end
        end
        end_prev = o_done || o_err;
      end
    end
  end

  task automatic push_tx(input logic [5:0] cmd, input logic [31:0] para);
    exp_t e;
    e = '{is_end: 1'b0, cmd: cmd, para: para, done: 1'b0, err: 1'b0, code: 3'd0, rca: 16'd0, ccs: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_end(input logic done, input logic err, input logic [2:0] code,
                          input logic [15:0] rca, input logic ccs);
    exp_t e;
    e = '{is_end: 1'b1, cmd: 6'd0, para: 32'd0, done: done, err: err, code: code, rca: rca, ccs: ccs};
    q.push_back(e);
  endtask

  // stop: 1 = ends after CMD8, 2 = after first CMD55, 3 = after the ACMD41
  // pairs, 5 = after CMD3, otherwise the full sequence through CMD7.
  task automatic push_seq(input int stop, input int pairs, input logic [15:0] rca7);
    push_tx(6'd0, 32'd0);
    push_tx(6'd8, 32'h0000_01AA);
    if (stop == 1) return;
    if (stop == 2) begin
      push_tx(6'd55, 32'd0);
      return;
    end
    for (int i = 0; i < pairs; i++) begin
      push_tx(6'd55, 32'd0);
      push_tx(6'd41, 32'h40FF_8000);
    end
    if (stop == 3) return;
    push_tx(6'd2, 32'd0);
    push_tx(6'd3, 32'd0);
    if (stop == 5) return;
    push_tx(6'd7, {rca7, 16'h0});
  endtask

  task automatic start_seq(input string name);
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    check({name, "_busy_after_start"}, o_busy, 1'b1);
    check({name, "_done_cleared"}, o_done, 1'b0);
    check({name, "_err_cleared"}, o_err, 1'b0);
    check({name, "_code_cleared"}, o_err_code, 3'd0);
  endtask

  task automatic wait_end(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (o_done || o_err) got = 1'b1;
    end
    check({name, "_reached_end"}, {63'd0, got}, 64'd1);
  endtask

  task automatic run_case(input string name, input int stop, input int pairs,
                          input logic [15:0] rca7, input logic is_err, input logic [2:0] code,
                          input logic [15:0] rca, input logic ccs, input bit poke);
    push_seq(stop, pairs, rca7);
    push_end(!is_err, is_err, code, rca, ccs);
    start_seq(name);
    if (poke) begin
      repeat (60) @(negedge clk);
      i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      check({name, "_start_ignored_busy"}, o_busy, 1'b1);
    end
    wait_end(name);
    repeat (40) @(negedge clk);
    check({name, "_queue_left"}, q.size(), 0);
  endtask

  // Global bound on run time.
  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, expected finish before 80000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    cfg_defaults();
    repeat (3) @(negedge clk);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_cmd", tx_cmd, 6'd0);
    check("rst_tx_para", tx_para, 32'd0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_code", o_err_code, 3'd0);
    check("rst_rca", o_rca, 16'd0);
    check("rst_ccs", o_ccs, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", o_busy, 1'b0);
    check("idle_tx_en", tx_en, 1'b0);

    // Happy path, with an i_start poke mid-sequence that must be ignored.
    cfg_defaults();
    run_case("happy", 6, 1, 16'h1234, 1'b0, 3'd0, 16'h1234, 1'b1, 1'b1);

    // Restart from DONE; card busy for three ACMD41 replies.
    cfg_defaults();
    cfg_busy_n = 3; cfg_ready_arg = 32'h80FF_8000; cfg_cmd3_arg = 32'hBEEF_0000;
    run_case("acmd41_busy3", 6, 4, 16'hBEEF, 1'b0, 3'd0, 16'hBEEF, 1'b0, 1'b0);

    // Ready on the last permitted attempt.
    cfg_defaults();
    cfg_busy_n = RETRY - 1; cfg_cmd3_arg = 32'h0042_0500;
    run_case("acmd41_last_try", 6, RETRY, 16'h0042, 1'b0, 3'd0, 16'h0042, 1'b1, 1'b0);

    // Card never ready: error 5 after RETRY attempts, RCA/CCS kept.
    cfg_defaults();
    cfg_busy_n = 1000;
    run_case("acmd41_exhaust", 3, RETRY, 16'h0, 1'b1, 3'd5, 16'h0042, 1'b1, 1'b0);

    // Bad CMD8 echo; restart from ERR.
    cfg_defaults();
    cfg_cmd8_arg = 32'h0000_00AA;
    run_case("cmd8_echo", 1, 0, 16'h0, 1'b1, 3'd2, 16'h0042, 1'b1, 1'b0);

    // No reply to CMD55: timeout exactly T cycles after busy falls.
    cfg_defaults();
    cfg_mute_cmd = 55;
    run_case("cmd55_silent", 2, 0, 16'h0, 1'b1, 3'd1, 16'h0042, 1'b1, 1'b0);
    check("cmd55_timeout_latency", end_edge - busy_fall_edge, T);

    // CMD3 CRC failure: RCA must not load.
    cfg_defaults();
    cfg_cmd3_crc = 1'b0; cfg_cmd3_arg = 32'h7777_0000;
    run_case("cmd3_crc", 5, 1, 16'h0, 1'b1, 3'd3, 16'h0042, 1'b1, 1'b0);

    // CMD7 wrong index.
    cfg_defaults();
    cfg_cmd7_idx = 6'd6; cfg_cmd3_arg = 32'h5555_0000; cfg_ready_arg = 32'h80FF_8000;
    run_case("cmd7_index", 6, 1, 16'h5555, 1'b1, 3'd4, 16'h5555, 1'b0, 1'b0);

    // Every response on the last accepted cycle.
    cfg_defaults();
    cfg_delay = T; cfg_cmd3_arg = 32'h0A0B_0000;
    run_case("rsp_last_cycle", 6, 1, 16'h0A0B, 1'b0, 3'd0, 16'h0A0B, 1'b1, 1'b0);

    // One cycle too late: timeout on CMD8, late pulse ignored.
    cfg_defaults();
    cfg_delay = T + 1;
    run_case("rsp_one_late", 1, 0, 16'h0, 1'b1, 3'd1, 16'h0A0B, 1'b1, 1'b0);
    check("cmd8_timeout_latency", end_edge - busy_fall_edge, T);

    // Reset while waiting for the CMD8 response.
    begin
      bit got;
      int seen;
      cfg_defaults();
      cfg_delay = 50;
      last_fall_cmd = -1;
      push_seq(1, 0, 16'h0);
      start_seq("reset_mid");
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        if (last_fall_cmd == 8) got = 1'b1;
      end
      check("reset_mid_cmd8_sent", {63'd0, got}, 64'd1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      epoch++;
      #1;
      check("reset_mid_tx_en", tx_en, 1'b0);
      check("reset_mid_busy", o_busy, 1'b0);
      check("reset_mid_done", o_done, 1'b0);
      check("reset_mid_err", o_err, 1'b0);
      check("reset_mid_code", o_err_code, 3'd0);
      check("reset_mid_rca", o_rca, 16'd0);
      check("reset_mid_ccs", o_ccs, 1'b0);
      check("reset_mid_tx_para", tx_para, 32'd0);
      check("reset_mid_queue", q.size(), 0);
      seen = 0;
      repeat (4) begin
        @(negedge clk);
        seen += int'(tx_en);
      end
      check("reset_hold_no_tx_en", seen, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("reset_mid_idle", o_busy, 1'b0);
    end

    // Fresh run after reset starts at CMD0 and completes.
    cfg_defaults();
    run_case("after_reset", 6, 1, 16'h1234, 1'b0, 3'd0, 16'h1234, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
